booth_multiplier_r4: RTL



---
 rtl/booth_multiplier_r4.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/booth_multiplier_r4.sv
// ---------------------------------------------------------------------------
// booth_multiplier_r4
//
// Radix-4 (modified Booth) sequential multiplier. It retires two multiplier
// bits per clock, so a transaction takes WIDTH/2+1 iterations. Each
// transaction can be signed or unsigned. A start/ready handshake sits in
// front of the datapath, and a one-cycle done pulse marks each new result.
//
// Parameters
//   WIDTH        operand width in bits (even, >= 4)
//
// Ports
//   clk          clock, rising edge active
//   rst          asynchronous active-low reset
//   m            multiplicand, sampled when a start is accepted
//   r            multiplier, sampled when a start is accepted
//   signed_mode  1 = two's complement operands, 0 = unsigned
//   start        request a multiplication (honoured only while ready)
//   ans          product register, holds the last completed result
//   ready        idle and able to accept start
//   done         one-cycle pulse in the first cycle a new ans is valid
// ---------------------------------------------------------------------------
module booth_multiplier_r4 #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     m,
   input  logic [WIDTH-1:0]     r,
   input  logic                 signed_mode,
   input  logic                 start,
   output logic [2*WIDTH-1:0]   ans,
   output logic                 ready,
   output logic                 done
);

   // Iteration count, extended operand width, accumulator width and the
   // width of the combined {accumulator, multiplier, r[-1]} shift register.
   localparam int N  = WIDTH / 2 + 1;
   localparam int EW = WIDTH + 2;
   localparam int AW = WIDTH + 4;
   localparam int PW = AW + EW + 1;
   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q;
   logic [EW-1:0]        mult_q;
   logic [PW-1:0]        prod_q;
   logic [CW-1:0]        cnt_q;
   logic [2*WIDTH-1:0]   ans_q;
   logic                 ready_q;
   logic                 done_q;

   logic [EW-1:0]        mExt;
   logic [EW-1:0]        rExt;
   logic [AW-1:0]        multWide;
   logic [AW-1:0]        pp;
   logic [AW-1:0]        accSum;
   logic [PW-1:0]        prod_d;

   // Widen both operands by two bits so that every operand fits as a
   // signed value. Signed operands are sign-extended and unsigned operands
   // are zero-extended. After this step the datapath only does signed
   // arithmetic. No separate mode register is needed, because the mode is
   // captured in the extended operands.
   always_comb begin
      mExt = '0;
      rExt = '0;
      if (signed_mode) begin
         mExt = {{2{m[WIDTH-1]}}, m};
         rExt = {{2{r[WIDTH-1]}}, r};
      end else begin
         mExt = {2'b00, m};
         rExt = {2'b00, r};
      end
   end

   // One radix-4 Booth step. The low three bits of the shift register are
   // the triplet {r[2i+1], r[2i], r[2i-1]}, because r[-1] starts as the
   // appended zero. The triplet selects 0, +-M or +-2M. That value is added
   // to the accumulator, which has two bits of headroom over the extended
   // multiplicand so that +-2M plus the running sum cannot overflow. The
   // whole register is then shifted right arithmetically by two.
   always_comb begin
      multWide = {{(AW-EW){mult_q[EW-1]}}, mult_q};
      pp       = '0;
      case (prod_q[2:0])
         3'b001, 3'b010: pp = multWide;
         3'b011:         pp = multWide << 1;
         3'b100:         pp = -(multWide << 1);
         3'b101, 3'b110: pp = -multWide;
         default:        pp = '0;
      endcase
      accSum = prod_q[PW-1 -: AW] + pp;
      prod_d = {{2{accSum[AW-1]}}, accSum, prod_q[EW:2]};
   end

   // Control FSM and datapath registers.
   // IDLE latches the operands when start arrives. CALC runs one Booth step
   // per edge. The edge that finishes the last step also captures the
   // product into ans and raises done. DONE lasts exactly one cycle and then
   // re-opens the handshake. ready and done are registered so that no input
   // reaches an output combinationally. The product bits start at bit 1,
   // because bit 0 of the shift register is the leftover r[-1] slot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         mult_q  <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
         ans_q   <= '0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  mult_q  <= mExt;
                  prod_q  <= {{AW{1'b0}}, rExt, 1'b0};
                  cnt_q   <= '0;
                  state_q <= CALC;
                  ready_q <= 1'b0;
               end
            end
            CALC: begin
               prod_q <= prod_d;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == CW'(N - 1)) begin
                  ans_q   <= prod_d[2*WIDTH:1];
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign ans   = ans_q;
   assign ready = ready_q;
   assign done  = done_q;

endmodule
